// File: rtl/echo_canceller.sv
// echo_canceller: FIR echo removal, x[n] = y[n] - (y[n-D] >>> SHIFT), with a PRIME phase
// that masks stale history until D samples have been captured since reset.
module echo_canceller #(
    parameter int DELAY_LEN = 2048,
    parameter int SHIFT = 2
) (
    input  logic        sample_clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] input_sample,
    output logic        out_valid,
    output logic [15:0] output_sample,
    output logic        wrap,
    output logic        primed
);
    localparam int AW = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;
    localparam logic [AW-1:0] LAST = AW'(DELAY_LEN - 1);
    typedef enum logic {PRIME, RUN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] output_sample_q, output_sample_d;
    logic out_valid_q, out_valid_d, wrap_q, wrap_d;
    logic [15:0] mem [DELAY_LEN];
    logic signed [15:0] delayed, atten, diff;
    always_comb begin
        delayed = (state_q == RUN) ? $signed(mem[wr_ptr_q]) : 16'sd0;
        atten = delayed >>> SHIFT;
        diff = $signed(input_sample) - atten;
        // While priming, the write pointer doubles as the fill count.
        state_d = (in_valid && wr_ptr_q == LAST) ? RUN : state_q;
        wr_ptr_d = in_valid ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        output_sample_d = in_valid ? diff : output_sample_q;
        wrap_d = in_valid ? ((input_sample[15] != atten[15]) && (diff[15] != input_sample[15])) : wrap_q;
        out_valid_d = in_valid;
    end
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            state_q <= PRIME;
            wr_ptr_q <= '0;
            output_sample_q <= '0;
            out_valid_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            output_sample_q <= output_sample_d;
            out_valid_q <= out_valid_d;
            wrap_q <= wrap_d;
        end
    end
    always_ff @(posedge sample_clock) begin
        if (in_valid && !reset) mem[wr_ptr_q] <= input_sample;
    end
    assign out_valid = out_valid_q;
    assign output_sample = output_sample_q;
    assign wrap = wrap_q;
    assign primed = (state_q == RUN);
endmodule
